// File: rtl/pipe_controller.sv
// Scrolling pipe obstacle controller: four pipes move left on each game tick,
// wrap to the right with a fresh LFSR gap height, and score when the bird clears one.
module pipe_controller #(
  parameter int          SCALE        = 32'sd2,
  parameter int          PIPE_SPACING = 32'sd200,
  parameter int          SPEED        = 32'sd2,
  parameter int          Y_MIN        = 32'sd150,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               VGA_clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [3:0]         game_state,
  input  logic signed [31:0] birdX,
  output logic signed [31:0] pipeX_1,
  output logic signed [31:0] pipeX_2,
  output logic signed [31:0] pipeX_3,
  output logic signed [31:0] pipeX_4,
  output logic signed [31:0] pipeY_1,
  output logic signed [31:0] pipeY_2,
  output logic signed [31:0] pipeY_3,
  output logic signed [31:0] pipeY_4,
  output logic [7:0]         score,
  output logic               pass_pulse
);

  localparam int PIPE_W = 32'sd26 * SCALE;
  localparam int X0     = 32'sd640;
  localparam int WRAP   = 32'sd4 * PIPE_SPACING;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  // Fibonacci step, taps 16,14,13,11 expressed on the right-shifting register
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  state_t             state_r, state_nx_s;
  logic [15:0]        lfsr_r;
  logic signed [31:0] px_r [4];
  logic signed [31:0] py_r [4];
  logic signed [31:0] px_nx_s [4];
  logic signed [31:0] py_nx_s [4];
  logic signed [31:0] px_dec_s [4];
  logic signed [31:0] y_new_s;
  logic [7:0]         score_r, score_nx_s;
  logic               pulse_r, pulse_nx_s;
  logic               any_pass_s;

  assign y_new_s = 32'(Y_MIN) + {25'd0, lfsr_r[6:0]};

  // Next FSM state from the one-hot game state; unknown encodings hold
  always_comb begin
    state_nx_s = state_r;
    case (game_state)
      4'b0001:          state_nx_s = ST_INIT;
      4'b0010:          state_nx_s = ST_RUN;
      4'b0100, 4'b1000: state_nx_s = ST_FROZEN;
      default:          state_nx_s = state_r;
    endcase
  end

  // Pipe motion, wrap, and scoring for the current FSM state
  always_comb begin
    any_pass_s = 1'b0;
    score_nx_s = score_r;
    pulse_nx_s = 1'b0;
    for (int k = 32'sd0; k < 32'sd4; k++) begin
      px_dec_s[k] = px_r[k] - SPEED;
      px_nx_s[k]  = px_r[k];
      py_nx_s[k]  = py_r[k];
    end
    case (state_r)
      ST_INIT: begin
        for (int k = 32'sd0; k < 32'sd4; k++) begin
          px_nx_s[k] = X0 + k * PIPE_SPACING;
          py_nx_s[k] = y_new_s;
        end
        score_nx_s = 8'd0;
      end
      ST_RUN: begin
        if (tick) begin
          for (int k = 32'sd0; k < 32'sd4; k++) begin
            // pass test uses the pre-wrap decremented position
            if ((px_r[k] + PIPE_W >= birdX) && (px_dec_s[k] + PIPE_W < birdX)) begin
              any_pass_s = 1'b1;
            end else begin
              any_pass_s = any_pass_s;
            end
            if (px_dec_s[k] < -PIPE_W) begin
              px_nx_s[k] = px_dec_s[k] + WRAP;
              py_nx_s[k] = y_new_s;
            end else begin
              px_nx_s[k] = px_dec_s[k];
            end
          end
          if (any_pass_s && (score_r != 8'd255)) begin
            score_nx_s = score_r + 8'd1;
            pulse_nx_s = 1'b1;
          end else begin
            score_nx_s = score_r;
          end
        end else begin
          score_nx_s = score_r;
        end
      end
      ST_FROZEN: score_nx_s = score_r;
      default:   score_nx_s = score_r;
    endcase
  end

  // State, LFSR and output registers
  always_ff @(posedge VGA_clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_INIT;
      lfsr_r  <= LFSR_SEED;
      for (int k = 32'sd0; k < 32'sd4; k++) begin
        px_r[k] <= X0 + k * PIPE_SPACING;
        py_r[k] <= 32'(Y_MIN) + {25'd0, LFSR_SEED[6:0]};
      end
      score_r <= 8'd0;
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      lfsr_r  <= lfsr_step(lfsr_r);
      for (int k = 32'sd0; k < 32'sd4; k++) begin
        px_r[k] <= px_nx_s[k];
        py_r[k] <= py_nx_s[k];
      end
      score_r <= score_nx_s;
      pulse_r <= pulse_nx_s;
    end
  end

  assign pipeX_1    = px_r[0];
  assign pipeX_2    = px_r[1];
  assign pipeX_3    = px_r[2];
  assign pipeX_4    = px_r[3];
  assign pipeY_1    = py_r[0];
  assign pipeY_2    = py_r[1];
  assign pipeY_3    = py_r[2];
  assign pipeY_4    = py_r[3];
  assign score      = score_r;
  assign pass_pulse = pulse_r;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: stimulus queues expected values,
// a negedge monitor pops and compares them and checks every pass_pulse.
module tb_pipe_controller;

  logic               VGA_clk;
  logic               rst;
  logic               tick;
  logic [3:0]         game_state;
  logic signed [31:0] birdX;
  logic signed [31:0] pipeX_1, pipeX_2, pipeX_3, pipeX_4;
  logic signed [31:0] pipeY_1, pipeY_2, pipeY_3, pipeY_4;
  logic [7:0]         score;
  logic               pass_pulse;

  pipe_controller dut (
    .VGA_clk    (VGA_clk),
    .rst        (rst),
    .tick       (tick),
    .game_state (game_state),
    .birdX      (birdX),
    .pipeX_1    (pipeX_1),
    .pipeX_2    (pipeX_2),
    .pipeX_3    (pipeX_3),
    .pipeX_4    (pipeX_4),
    .pipeY_1    (pipeY_1),
    .pipeY_2    (pipeY_2),
    .pipeY_3    (pipeY_3),
    .pipeY_4    (pipeY_4),
    .score      (score),
    .pass_pulse (pass_pulse)
  );

  localparam logic [3:0] GS_START = 4'b0001;
  localparam logic [3:0] GS_GAME  = 4'b0010;
  localparam logic [3:0] GS_PAUSE = 4'b0100;

  // signal selectors for expectations
  localparam int S_PX1 = 0, S_PX2 = 1, S_PX3 = 2, S_PX4 = 3, S_PY1 = 4, S_SCORE = 5, S_PULSE = 6;

  typedef struct {
    string name;
    int    sel;
    int    lo;
    int    hi;
  } exp_t;

  exp_t exp_q[$];
  int   pass_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t mon_e;
  int   mon_v;
  int   mon_w;

  initial VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  function automatic int get_val(input int sel);
    case (sel)
      S_PX1:   return pipeX_1;
      S_PX2:   return pipeX_2;
      S_PX3:   return pipeX_3;
      S_PX4:   return pipeX_4;
      S_PY1:   return pipeY_1;
      S_SCORE: return int'(score);
      S_PULSE: return int'(pass_pulse);
      default: return -99999;
    endcase
  endfunction

  task automatic expect_eq(input string n, input int sel, input int v);
    exp_q.push_back('{name: n, sel: sel, lo: v, hi: v});
  endtask

  task automatic expect_rng(input string n, input int sel, input int lo, input int hi);
    exp_q.push_back('{name: n, sel: sel, lo: lo, hi: hi});
  endtask

  // one clock edge with tick driven to t; returns 1 time unit after the edge
  task automatic cyc(input logic t);
    tick = t;
    @(posedge VGA_clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic expect_reset_vals(input string tag);
    expect_eq({tag, "_px1"}, S_PX1, 640);
    expect_eq({tag, "_px2"}, S_PX2, 840);
    expect_eq({tag, "_px3"}, S_PX3, 1040);
    expect_eq({tag, "_px4"}, S_PX4, 1240);
    expect_eq({tag, "_py1"}, S_PY1, 247);
    expect_eq({tag, "_score"}, S_SCORE, 0);
    expect_eq({tag, "_pulse"}, S_PULSE, 0);
  endtask

  // Monitor: drain queued expectations and check each score strobe
  always @(negedge VGA_clk) begin
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_v = get_val(mon_e.sel);
      n_cmp++;
      if (mon_v < mon_e.lo || mon_v > mon_e.hi) begin
        n_fail++;
        $display("FAIL %s: got %0d, want %0d..%0d", mon_e.name, mon_v, mon_e.lo, mon_e.hi);
      end
    end
    if (pass_pulse === 1'b1) begin
      n_cmp++;
      if (pass_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pass_pulse: got pulse with score %0d, want no pulse", score);
      end else begin
        mon_w = pass_q.pop_front();
        if (int'(score) != mon_w) begin
          n_fail++;
          $display("FAIL pulse_score: got %0d, want %0d", score, mon_w);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: got no end of run, want finish within budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    tick       = 1'b0;
    game_state = GS_START;
    birdX      = 32'sd100;
    #3;
    expect_reset_vals("por");
    @(posedge VGA_clk);
    #1;
    rst = 1'b1;

    // INIT reloads every cycle; gap height follows the LFSR from ACE1
    cyc(1'b1);
    expect_eq("init_py_c1", S_PY1, 247);
    cyc(1'b1);
    expect_eq("init_py_c2", S_PY1, 262);
    cyc(1'b1);
    expect_eq("init_py_c3", S_PY1, 206);
    repeat (7) cyc(1'b1);
    expect_eq("init_px1", S_PX1, 640);
    expect_eq("init_px2", S_PX2, 840);
    expect_eq("init_px3", S_PX3, 1040);
    expect_eq("init_px4", S_PX4, 1240);
    expect_eq("init_score", S_SCORE, 0);

    // tick on the IN_GAME transition edge is evaluated in INIT
    game_state = GS_GAME;
    cyc(1'b1);
    expect_eq("enter_run_px1", S_PX1, 640);
    repeat (5) cyc(1'b1);
    expect_eq("run5_px1", S_PX1, 630);
    expect_eq("run5_px2", S_PX2, 830);
    expect_eq("run5_px3", S_PX3, 1030);
    expect_eq("run5_px4", S_PX4, 1230);

    // tick on the PAUSE transition edge still moves; later ticks do not
    game_state = GS_PAUSE;
    cyc(1'b1);
    expect_eq("pause_edge_px1", S_PX1, 628);
    cyc(1'b1);
    expect_eq("paused_px1", S_PX1, 628);
    expect_eq("paused_px4", S_PX4, 1228);
    game_state = 4'b0011;
    cyc(1'b1);
    expect_eq("bad_enc_px1", S_PX1, 628);
    game_state = GS_GAME;
    cyc(1'b0);

    // pipe 1 reaches 48 -> next tick clears the bird at 100
    repeat (290) cyc(1'b1);
    expect_eq("prepass_px1", S_PX1, 48);
    expect_eq("prepass_score", S_SCORE, 0);
    pass_q.push_back(1);
    cyc(1'b1);
    expect_eq("pass_px1", S_PX1, 46);
    expect_eq("pass_score", S_SCORE, 1);
    expect_eq("pass_pulse_hi", S_PULSE, 1);
    cyc(1'b1);
    expect_eq("pass2_score", S_SCORE, 1);
    expect_eq("pass2_pulse_lo", S_PULSE, 0);

    // wrap: -52 - 2 < -52 -> -54 + 800 = 746, spacing to pipe 2 kept
    repeat (48) cyc(1'b1);
    expect_eq("prewrap_px1", S_PX1, -52);
    cyc(1'b1);
    expect_eq("wrap_px1", S_PX1, 746);
    expect_eq("wrap_px2", S_PX2, 146);
    expect_rng("wrap_py1", S_PY1, 150, 277);

    // passes every 100 ticks from here; 255th at tick 25350
    for (int s = 2; s <= 255; s++) pass_q.push_back(s);
    repeat (25350) cyc(1'b1);
    expect_eq("sat_score", S_SCORE, 255);
    expect_eq("sat_last_pulse", S_PULSE, 1);
    repeat (100) cyc(1'b1);
    expect_eq("sat_hold_score", S_SCORE, 255);
    expect_eq("sat_no_pulse", S_PULSE, 0);

    // reset mid-RUN with tick held high
    tick = 1'b1;
    @(posedge VGA_clk);
    #1;
    rst = 1'b0;
    #2;
    expect_reset_vals("mid_rst");
    @(posedge VGA_clk);
    #1;
    expect_eq("in_rst_px1", S_PX1, 640);
    expect_eq("in_rst_py1", S_PY1, 247);
    game_state = GS_START;
    @(posedge VGA_clk);
    #1;
    rst = 1'b1;
    @(posedge VGA_clk);
    #1;
    expect_eq("rel_py_c1", S_PY1, 247);
    expect_eq("rel_px1", S_PX1, 640);
    @(posedge VGA_clk);
    #1;
    expect_eq("rel_py_c2", S_PY1, 262);
    game_state = GS_GAME;
    tick = 1'b0;
    @(posedge VGA_clk);
    #1;
    expect_eq("rel_run_px1", S_PX1, 640);
    cyc(1'b1);
    expect_eq("rel_tick_px1", S_PX1, 638);
    expect_eq("rel_tick_px4", S_PX4, 1238);
    expect_eq("rel_tick_score", S_SCORE, 0);

    @(negedge VGA_clk);
    #1;
    n_cmp++;
    if (pass_q.size() != 0) begin
      n_fail++;
      $display("FAIL pass_queue_drained: got %0d pending pulses, want 0", pass_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
